// File: rtl/led_scan_driver_if.sv
// ----------------------------------------------------------------------------
// led_scan_driver_if
//   Groups the framebuffer read port and the HUB75-style panel pins driven by
//   led_scan_driver.
//
//   Framebuffer read protocol (there is no ready/backpressure): fb_ren is a
//   one-cycle request strobe carrying fb_raddr = {row[4:0], col[5:0]}. The
//   memory must present fb_rdata exactly one cycle after the strobe, with
//   [0] = pixel (row, col) and [1] = pixel (row+32, col).
//
//   Signals
//     fb_ren, fb_raddr[10:0]   read request (driver -> memory)
//     fb_rdata[1:0]            read data    (memory -> driver)
//     hub_r1, hub_r2           serial pixel data, upper / lower panel half
//     hub_clk                  shift clock, panel samples data on its rise
//     hub_lat                  latch strobe
//     hub_oe_n                 active-low output enable
//     hub_addr[4:0]            row-pair select
//     frame_sync               one-cycle pulse at the start of row 0
//
//   Modports: master = scan driver, slave = framebuffer / panel side.
// ----------------------------------------------------------------------------
interface led_scan_driver_if;
   logic        fb_ren;
   logic [10:0] fb_raddr;
   logic [1:0]  fb_rdata;
   logic        hub_r1;
   logic        hub_r2;
   logic        hub_clk;
   logic        hub_lat;
   logic        hub_oe_n;
   logic [4:0]  hub_addr;
   logic        frame_sync;

   modport master (
      output fb_ren, fb_raddr,
      input  fb_rdata,
      output hub_r1, hub_r2, hub_clk, hub_lat, hub_oe_n, hub_addr, frame_sync
   );

   modport slave (
      input  fb_ren, fb_raddr,
      output fb_rdata,
      input  hub_r1, hub_r2, hub_clk, hub_lat, hub_oe_n, hub_addr, frame_sync
   );
endinterface

// File: rtl/led_scan_driver.sv
// ----------------------------------------------------------------------------
// led_scan_driver
//   Scans a 64x64 LED panel (two 32-row halves shifted in parallel) from a
//   2-bit-wide framebuffer. Each row goes through:
//     PRE0 (1)  -> issue read of column 0, frame_sync on row 0
//     PRE1 (1)  -> capture column 0 pixels
//     SHIFT(128)-> 64 columns x 2 phases (A: clk low, B: clk high)
//     BLANK(1)  -> hub_addr switches to the row just shifted
//     LATCH(1)  -> hub_lat pulse
//     DISPLAY(ON_CYCLES) -> hub_oe_n low
//   giving a row period of ON_CYCLES+132 cycles.
//
//   Ports
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     enable     1 = scan; 0 = stop into IDLE at the end of the current row
//     bus        led_scan_driver_if.master (framebuffer + panel pins)
//     dbg_state  current FSM state code
//
//   Parameter
//     ON_CYCLES  display cycles per row (>= 1)
// ----------------------------------------------------------------------------
module led_scan_driver #(
   parameter int ON_CYCLES = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   led_scan_driver_if.master        bus,
   output logic [2:0]               dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRE0    = 3'd1,
      PRE1    = 3'd2,
      SHIFT   = 3'd3,
      BLANK   = 3'd4,
      LATCH   = 3'd5,
      DISPLAY = 3'd6
   } state_t;

   localparam int ON_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
   localparam logic [ON_W-1:0] ON_LAST = ON_W'(ON_CYCLES - 1);

   state_t          state;
   state_t          state_nx;
   logic [4:0]      row;
   logic [5:0]      col;
   logic            phase;     // 0 = phase A (clk low), 1 = phase B (clk high)
   logic [ON_W-1:0] on_cnt;
   logic [1:0]      pix;       // pixels currently on r1/r2
   logic [4:0]      addr_q;    // row-pair select shown to the panel

   logic shift_done;
   logic disp_done;

   assign shift_done = (state == SHIFT) && phase && (col == 6'd63);
   assign disp_done  = (state == DISPLAY) && (on_cnt == ON_LAST);

   // ---------------------------------------------------------------------
   // State register and counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         row    <= 5'd0;
         col    <= 6'd0;
         phase  <= 1'b0;
         on_cnt <= '0;
         pix    <= 2'b00;
         addr_q <= 5'd0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               row <= 5'd0;
            end
            PRE1: begin
               // Data for column 0 requested in PRE0 is valid now.
               pix   <= bus.fb_rdata;
               col   <= 6'd0;
               phase <= 1'b0;
            end
            SHIFT: begin
               phase <= ~phase;
               if (phase) begin
                  // End of phase B: the read issued in phase A returns now
                  // and becomes the next column's pixels. Column 63 issued
                  // no read, so nothing is captured; col rolls 63 -> 0.
                  col <= col + 6'd1;
                  if (col != 6'd63) begin
                     pix <= bus.fb_rdata;
                  end
               end
               // Loaded on the last SHIFT cycle so it is visible in BLANK.
               if (shift_done) begin
                  addr_q <= row;
               end
            end
            DISPLAY: begin
               if (disp_done) begin
                  on_cnt <= '0;
                  row    <= enable ? (row + 5'd1) : 5'd0;
               end else begin
                  on_cnt <= on_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable) state_nx = PRE0;
         PRE0:    state_nx = PRE1;
         PRE1:    state_nx = SHIFT;
         SHIFT:   if (shift_done) state_nx = BLANK;
         BLANK:   state_nx = LATCH;
         LATCH:   state_nx = DISPLAY;
         DISPLAY: if (disp_done) state_nx = enable ? PRE0 : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   always_comb begin
      bus.fb_ren     = 1'b0;
      bus.fb_raddr   = 11'd0;
      bus.hub_r1     = 1'b0;
      bus.hub_r2     = 1'b0;
      bus.hub_clk    = 1'b0;
      bus.hub_lat    = 1'b0;
      bus.hub_oe_n   = 1'b1;
      bus.frame_sync = 1'b0;
      case (state)
         PRE0: begin
            bus.fb_ren     = 1'b1;
            bus.fb_raddr   = {row, 6'd0};
            bus.frame_sync = (row == 5'd0);
         end
         SHIFT: begin
            bus.hub_clk = phase;
            bus.hub_r1  = pix[0];
            bus.hub_r2  = pix[1];
            // Prefetch the next column during phase A.
            if (!phase && (col != 6'd63)) begin
               bus.fb_ren   = 1'b1;
               bus.fb_raddr = {row, col + 6'd1};
            end
         end
         LATCH: begin
            bus.hub_lat = 1'b1;
         end
         DISPLAY: begin
            bus.hub_oe_n = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.hub_addr = addr_q;
   assign dbg_state    = state;

endmodule

// File: tb/tb_led_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_led_scan_driver
//   Bench for led_scan_driver with ON_CYCLES = 4 (row period 136 cycles).
//   A framebuffer model answers reads one cycle after fb_ren. Outputs are
//   sampled 1 time unit after each rising clk edge.
// ----------------------------------------------------------------------------
module tb_led_scan_driver;

  localparam int ON = 4;
  localparam int P  = ON + 132;

  typedef struct packed {
    logic        ren;
    logic [10:0] raddr;
    logic        r1;
    logic        r2;
    logic        hclk;
    logic        lat;
    logic        oe_n;
    logic [4:0]  addr;
    logic        fs;
  } outs_t;

  typedef struct {
    int    t;
    string name;
    outs_t exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  led_scan_driver_if bus ();

  led_scan_driver #(.ON_CYCLES(ON)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Framebuffer: data valid exactly one cycle after the read strobe.
  logic [1:0] mem [0:2047];

  always @(posedge clk) begin
    bus.fb_rdata <= bus.fb_ren ? mem[bus.fb_raddr] : 2'b00;
  end

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  int t_now   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to(input int t);
    while (t_now < t) begin
      tick();
      t_now++;
    end
  endtask

  function automatic outs_t sample();
    outs_t s;
    s.ren   = bus.fb_ren;
    s.raddr = bus.fb_raddr;
    s.r1    = bus.hub_r1;
    s.r2    = bus.hub_r2;
    s.hclk  = bus.hub_clk;
    s.lat   = bus.hub_lat;
    s.oe_n  = bus.hub_oe_n;
    s.addr  = bus.hub_addr;
    s.fs    = bus.frame_sync;
    return s;
  endfunction

  function automatic outs_t mk(input int ren, input int raddr, input int r1, input int r2,
                               input int hclk, input int lat, input int oe_n,
                               input int addr, input int fs);
    outs_t e;
    e.ren   = 1'(ren);
    e.raddr = 11'(raddr);
    e.r1    = 1'(r1);
    e.r2    = 1'(r2);
    e.hclk  = 1'(hclk);
    e.lat   = 1'(lat);
    e.oe_n  = 1'(oe_n);
    e.addr  = 5'(addr);
    e.fs    = 1'(fs);
    return e;
  endfunction

  task automatic check_outs(input string name, input outs_t act, input outs_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d: got ren=%b raddr=%h r1=%b r2=%b clk=%b lat=%b oe_n=%b addr=%0d fs=%b, expected ren=%b raddr=%h r1=%b r2=%b clk=%b lat=%b oe_n=%b addr=%0d fs=%b",
                  name, t_now, act.ren, act.raddr, act.r1, act.r2, act.hclk, act.lat, act.oe_n, act.addr, act.fs,
                  exp.ren, exp.raddr, exp.r1, exp.r2, exp.hclk, exp.lat, exp.oe_n, exp.addr, exp.fs);
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d: got %0h expected %0h", name, t_now, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Expected outputs t cycles after the first PRE0 of a continuous scan
  // started from reset, derived from the row timeline:
  //   offset 0 read col 0, 1 idle, 2..129 shift, 130 blank, 131 latch,
  //   132.. display.
  function automatic outs_t model(input int t);
    outs_t e;
    int k   = t / P;
    int o   = t % P;
    int r   = k % 32;
    int c;
    bit pb;
    e = '0;
    e.oe_n = 1'b1;
    e.addr = (o >= 130) ? 5'(r) : ((k == 0) ? 5'd0 : 5'((k - 1) % 32));
    if (o == 0) begin
      e.ren   = 1'b1;
      e.raddr = 11'(r * 64);
      e.fs    = (r == 0);
    end else if (o >= 2 && o < 130) begin
      c  = (o - 2) / 2;
      pb = ((o - 2) % 2) == 1;
      e.hclk = pb;
      e.r1   = mem[r * 64 + c][0];
      e.r2   = mem[r * 64 + c][1];
      if (!pb && c < 63) begin
        e.ren   = 1'b1;
        e.raddr = 11'(r * 64 + c + 1);
      end
    end else if (o == 131) begin
      e.lat = 1'b1;
    end else if (o >= 132) begin
      e.oe_n = 1'b0;
    end
    return e;
  endfunction

  // Reset with the given enable, then step to the first PRE0 (t = 0).
  task automatic start_scan();
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    t_now = 0;
  endtask

  // ---------------- test ----------------
  vec_t tbl [20];
  int   fs_times [$];
  outs_t rst_vals;

  initial begin
    rst_vals = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Pixel-order framebuffer: (row 0, col 5) top and (row 40, col 63).
    for (int i = 0; i < 2048; i++) mem[i] = 2'b00;
    mem[5]   = 2'b01;
    mem[575] = 2'b10;

    //            t     name            ren raddr r1 r2 clk lat oe addr fs
    tbl[0]  = '{0,    "pre0_row0",   mk(1, 0,   0, 0, 0, 0, 1, 0, 1)};
    tbl[1]  = '{1,    "pre1_row0",   mk(0, 0,   0, 0, 0, 0, 1, 0, 0)};
    tbl[2]  = '{2,    "col0_a",      mk(1, 1,   0, 0, 0, 0, 1, 0, 0)};
    tbl[3]  = '{3,    "col0_b",      mk(0, 0,   0, 0, 1, 0, 1, 0, 0)};
    tbl[4]  = '{12,   "col5_a",      mk(1, 6,   1, 0, 0, 0, 1, 0, 0)};
    tbl[5]  = '{13,   "col5_b",      mk(0, 0,   1, 0, 1, 0, 1, 0, 0)};
    tbl[6]  = '{14,   "col6_a",      mk(1, 7,   0, 0, 0, 0, 1, 0, 0)};
    tbl[7]  = '{128,  "col63_a",     mk(0, 0,   0, 0, 0, 0, 1, 0, 0)};
    tbl[8]  = '{129,  "col63_b",     mk(0, 0,   0, 0, 1, 0, 1, 0, 0)};
    tbl[9]  = '{130,  "blank_row0",  mk(0, 0,   0, 0, 0, 0, 1, 0, 0)};
    tbl[10] = '{131,  "latch_row0",  mk(0, 0,   0, 0, 0, 1, 1, 0, 0)};
    tbl[11] = '{132,  "disp_first",  mk(0, 0,   0, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{135,  "disp_last",   mk(0, 0,   0, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{136,  "pre0_row1",   mk(1, 64,  0, 0, 0, 0, 1, 0, 0)};
    tbl[14] = '{1214, "r8_col62_a",  mk(1, 575, 0, 0, 0, 0, 1, 7, 0)};
    tbl[15] = '{1216, "r8_col63_a",  mk(0, 0,   0, 1, 0, 0, 1, 7, 0)};
    tbl[16] = '{1217, "r8_col63_b",  mk(0, 0,   0, 1, 1, 0, 1, 7, 0)};
    tbl[17] = '{1218, "blank_row8",  mk(0, 0,   0, 0, 0, 0, 1, 8, 0)};
    tbl[18] = '{1219, "latch_row8",  mk(0, 0,   0, 0, 0, 1, 1, 8, 0)};
    tbl[19] = '{1220, "disp_row8",   mk(0, 0,   0, 0, 0, 0, 0, 8, 0)};

    // ---- reset: rst held 3 cycles with enable=1 ----
    rst    = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("reset_hold", sample(), rst_vals);
    end
    rst = 1'b0;
    check_val("no_ren_before_release_edge", 32'(bus.fb_ren), 32'd0);
    tick();
    check_outs("first_pre0_after_reset", sample(), mk(1, 0, 0, 0, 0, 0, 1, 0, 1));

    // ---- table-driven pixel order and timing ----
    start_scan();
    for (int i = 0; i < 20; i++) begin
      advance_to(tbl[i].t);
      check_outs(tbl[i].name, sample(), tbl[i].exp);
    end

    // ---- random framebuffer, whole frame plus wrap against the model ----
    for (int i = 0; i < 2048; i++) mem[i] = 2'($urandom);
    start_scan();
    fs_times.delete();
    for (int t = 0; t <= 33 * P + 5; t++) begin
      advance_to(t);
      check_outs("model", sample(), model(t));
      if (bus.frame_sync === 1'b1) fs_times.push_back(t);
    end
    check_val("frame_sync_count", 32'(fs_times.size()), 32'd2);
    if (fs_times.size() >= 2)
      check_val("frame_period", 32'(fs_times[1] - fs_times[0]), 32'(32 * P));
    check_val("wrap_frame_sync_addr", 32'(model(32 * P).raddr), 32'd0);

    // ---- enable dropped during SHIFT of row 7 ----
    begin
      int drop_o;
      int idle_n;
      start_scan();
      drop_o = $urandom_range(2, 129);
      advance_to(7 * P + drop_o);
      enable = 1'b0;
      advance_to(7 * P + 131);
      check_val("en_latch_row7", {27'd0, bus.hub_lat, bus.hub_addr}, {27'd0, 1'b1, 5'd7});
      for (int o = 132; o < 136; o++) begin
        advance_to(7 * P + o);
        check_val("en_display_row7", 32'(bus.hub_oe_n), 32'd0);
      end
      idle_n = $urandom_range(3, 10);
      for (int i = 0; i < idle_n; i++) begin
        advance_to(t_now + 1);
        check_val("en_idle_quiet",
                  {25'd0, bus.fb_ren, bus.hub_lat, bus.hub_clk, bus.hub_oe_n,
                   bus.frame_sync, bus.hub_r1, bus.hub_r2},
                  {25'd0, 7'b0001000});
      end
      $display("info: idle state code %0d", dbg_state);
      enable = 1'b1;
      tick();
      check_val("reenable_row0", {20'd0, bus.fb_ren, bus.frame_sync, 5'd0, bus.fb_raddr[10:6]},
                {20'd0, 1'b1, 1'b1, 5'd0, 5'd0});
    end

    // ---- reset asserted during LATCH of row 3 ----
    start_scan();
    advance_to(3 * P + 131);
    check_val("rst_mid_latch_pre", {27'd0, bus.hub_lat, bus.hub_addr}, {27'd0, 1'b1, 5'd3});
    rst = 1'b1;
    tick();
    check_outs("rst_mid_latch_next", sample(), rst_vals);
    tick();
    check_outs("rst_mid_latch_hold", sample(), rst_vals);
    rst = 1'b0;
    tick();
    check_outs("rst_mid_restart", sample(), mk(1, 0, 0, 0, 0, 0, 1, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #2000000;
    $display("FAIL timeout: run exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
